// File: rtl/seg7_scan_to_bcd.sv
// Scanned 7-segment bus receiver: follows the one-hot digit strobe, waits for each
// digit's segment pattern to settle, decodes it to BCD and emits one word per frame.
module seg7_scan_to_bcd #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    sync_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

    // Returns {error, nibble}; unknown patterns decode to 4'hF with the error bit set.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_DIGITS-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << i;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [6:0]              last_seg_q, last_seg_d;
    logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    logic                    gap_q, gap_d;
    logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sync_err_q, sync_err_d;

    logic                    frame_done;
    logic [4:0]              dec;
    logic [CNT_W-1:0]        cnt_inc;
    logic [NUM_DIGITS-1:0]   sel_cur, sel_next, sel_first;

    // Scan tracking. gap_q records a blanking gap seen in HOLD, which a
    // single-digit display needs before the same strobe can start a new frame.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        last_seg_d = last_seg_q;
        work_bcd_d = work_bcd_q;
        work_err_d = work_err_q;
        gap_d      = gap_q;
        sync_err_d = 1'b0;
        frame_done = 1'b0;
        dec        = decode_seg(seg_in);
        cnt_inc    = cnt_q + CNT_ONE;
        sel_cur    = onehot(idx_q);
        sel_next   = onehot(idx_q + IDX_W'(1));
        sel_first  = onehot('0);

        case (state_q)
            ST_IDLE: begin
                if (digit_sel == sel_first) begin
                    state_d    = ST_SETTLE;
                    idx_d      = '0;
                    cnt_d      = CNT_ONE;
                    last_seg_d = seg_in;
                end
            end
            ST_SETTLE: begin
                if (digit_sel != sel_cur) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (seg_in != last_seg_q) begin
                    cnt_d      = CNT_ONE;
                    last_seg_d = seg_in;
                end else if (cnt_inc == CNT_DONE) begin
                    cnt_d                   = cnt_inc;
                    work_bcd_d[4*idx_q +: 4] = dec[3:0];
                    work_err_d[idx_q]       = dec[4];
                    state_d                 = ST_HOLD;
                    gap_d                   = 1'b0;
                    frame_done              = (idx_q == LAST_IDX);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (digit_sel == '0) begin
                    gap_d = 1'b1;
                end else if ((idx_q != LAST_IDX) && (digit_sel == sel_next)) begin
                    state_d    = ST_SETTLE;
                    idx_d      = idx_q + IDX_W'(1);
                    cnt_d      = CNT_ONE;
                    last_seg_d = seg_in;
                end else if ((idx_q == LAST_IDX) && (digit_sel == sel_first) &&
                             ((NUM_DIGITS > 1) || gap_q)) begin
                    state_d    = ST_SETTLE;
                    idx_d      = '0;
                    cnt_d      = CNT_ONE;
                    last_seg_d = seg_in;
                end else if (digit_sel == sel_cur) begin
                    state_d = ST_HOLD;
                end else begin
                    sync_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output word: valid/ready -- the word is offered while out_valid is high and is
    // consumed on any edge where out_valid && out_ready; it never changes while offered.
    always_comb begin
        bcd_out_d   = bcd_out_q;
        digit_err_d = digit_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                bcd_out_d   = work_bcd_d;
                digit_err_d = work_err_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_seg_q  <= '0;
            work_bcd_q  <= '0;
            work_err_q  <= '0;
            gap_q       <= 1'b0;
            bcd_out_q   <= '0;
            digit_err_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            last_seg_q  <= last_seg_d;
            work_bcd_q  <= work_bcd_d;
            work_err_q  <= work_err_d;
            gap_q       <= gap_d;
            bcd_out_q   <= bcd_out_d;
            digit_err_q <= digit_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign digit_err = digit_err_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Bench for seg7_scan_to_bcd: directed scans plus random frames checked against a
// table-lookup model of the display encoding.
module tb_seg7_scan_to_bcd;

    localparam int N = 4;
    localparam int S = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]   seg_in = '0;
    logic [N-1:0] digit_sel = '0;
    logic         out_ready = 1'b0;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]   digit_err;
    logic           out_valid;
    logic           overrun;
    logic           sync_err;

    seg7_scan_to_bcd #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .digit_sel (digit_sel),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .sync_err  (sync_err)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;
    logic [5*N-1:0] exp_q[$];
    logic [5*N-1:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({digit_err, bcd_out});
        if (sync_err) sync_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_digit(input logic [6:0] p);
        for (int d = 0; d < 10; d++)
            if (SEG_TAB[d] == p) return {1'b0, 4'(d)};
        return 5'h1F;
    endfunction

    function automatic logic [7*N-1:0] pats_of(input int a0, input int a1, input int a2, input int a3);
        return {SEG_TAB[a3], SEG_TAB[a2], SEG_TAB[a1], SEG_TAB[a0]};
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input logic [N-1:0] sel, input logic [6:0] seg);
        digit_sel = sel;
        seg_in    = seg;
        @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input logic [7*N-1:0] pats, input int hold, input int gap, input bit push_exp);
        logic [4*N-1:0] eb;
        logic [N-1:0]   ee;
        logic [N-1:0]   sel;
        logic [4:0]     r;
        for (int i = 0; i < N; i++) begin
            r = ref_digit(pats[7*i +: 7]);
            eb[4*i +: 4] = r[3:0];
            ee[i] = r[4];
            sel = '0;
            sel[i] = 1'b1;
            for (int c = 0; c < hold; c++) cyc(sel, pats[7*i +: 7]);
            for (int g = 0; g < gap; g++) cyc('0, 7'h00);
        end
        if (push_exp) exp_q.push_back({ee, eb});
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7*N-1:0] pats;
        int base_sync;

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd", bcd_out, 0);
        check("rst_err", digit_err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sync", sync_err, 0);
        rst_n = 1'b1;
        cyc('0, 7'h00);

        // clean frame 1,2,3,4
        scan_frame(pats_of(1, 2, 3, 4), 8, 0, 1'b1);
        cyc('0, 7'h00);
        check_frames("f1234");
        check("f1234_bcd_hold", bcd_out, 16'h4321);
        check("f1234_valid_drop", out_valid, 0);
        check("f1234_sync", sync_cnt, 0);

        // invalid pattern on digit 2
        pats = pats_of(5, 5, 5, 5);
        pats[14 +: 7] = 7'b0000001;
        scan_frame(pats, 8, 1, 1'b1);
        check("bad_bcd", bcd_out, 16'h5F55);
        check("bad_err", digit_err, 4'b0100);
        check_frames("bad");

        // bouncing segments on digits 1 and 3; last-digit latency is S-1 after settling
        base_sync = sync_cnt;
        for (int c = 0; c < 8; c++) cyc(4'b0001, SEG_TAB[0]);
        for (int c = 0; c < 6; c++) cyc(4'b0010, ((c / 2) % 2 == 0) ? SEG_TAB[1] : SEG_TAB[2]);
        for (int c = 0; c < 8; c++) cyc(4'b0010, SEG_TAB[7]);
        for (int c = 0; c < 8; c++) cyc(4'b0100, SEG_TAB[2]);
        for (int c = 0; c < 6; c++) cyc(4'b1000, ((c / 2) % 2 == 0) ? SEG_TAB[1] : SEG_TAB[2]);
        for (int c = 0; c < S - 1; c++) cyc(4'b1000, SEG_TAB[9]);
        check("lat_early", out_valid, 0);
        cyc(4'b1000, SEG_TAB[9]);
        check("lat_exact", out_valid, 1);
        check("bounce_bcd", bcd_out, 16'h9270);
        for (int c = 0; c < 3; c++) cyc(4'b1000, SEG_TAB[9]);
        exp_q.push_back({4'b0000, 16'h9270});
        check_frames("bounce");
        check("bounce_sync", sync_cnt - base_sync, 0);

        // digit 1 strobed too briefly
        base_sync = sync_cnt;
        for (int c = 0; c < 8; c++) cyc(4'b0001, SEG_TAB[1]);
        for (int c = 0; c < S - 1; c++) cyc(4'b0010, SEG_TAB[2]);
        cyc(4'b0100, SEG_TAB[3]);
        check("short_sync_pulse", sync_err, 1);
        cyc(4'b0100, SEG_TAB[3]);
        check("short_sync_once", sync_err, 0);
        for (int c = 0; c < 6; c++) cyc(4'b0100, SEG_TAB[3]);
        for (int c = 0; c < 8; c++) cyc(4'b1000, SEG_TAB[4]);
        check_frames("short_none");
        check("short_sync_cnt", sync_cnt - base_sync, 1);
        scan_frame(pats_of(8, 6, 4, 2), 6, 0, 1'b1);
        cyc('0, 7'h00);
        check_frames("short_recover");

        // random frames
        base_sync = sync_cnt;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) pats[7*i +: 7] = 7'($urandom_range(0, 127));
                else pats[7*i +: 7] = SEG_TAB[$urandom_range(0, 9)];
            end
            scan_frame(pats, $urandom_range(S, S + 4), $urandom_range(0, 2), 1'b1);
        end
        cyc('0, 7'h00);
        cyc('0, 7'h00);
        check_frames("rand");
        check("rand_sync", sync_cnt - base_sync, 0);
        check("rand_overrun", overrun, 0);

        // multi-hot strobe while holding
        for (int c = 0; c < 8; c++) cyc(4'b0001, SEG_TAB[3]);
        cyc(4'b0011, SEG_TAB[3]);
        check("hold_multi_sync", sync_err, 1);
        cyc(4'b0100, SEG_TAB[3]);
        check("hold_idle_quiet", sync_err, 0);
        cyc('0, 7'h00);
        scan_frame(pats_of(9, 8, 7, 6), 8, 0, 1'b1);
        check_frames("hold_recover");

        // consumer stalls across two frames
        out_ready = 1'b0;
        scan_frame(pats_of(1, 2, 3, 4), 8, 0, 1'b0);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_flag", overrun, 0);
        scan_frame(pats_of(5, 6, 7, 8), 8, 0, 1'b0);
        check("ovr_held_bcd", bcd_out, 16'h4321);
        check("ovr_flag", overrun, 1);
        out_ready = 1'b1;
        cyc('0, 7'h00);
        check("ovr_valid_drop", out_valid, 0);
        check("ovr_sticky", overrun, 1);
        check("ovr_bcd_after", bcd_out, 16'h4321);
        exp_q.push_back({4'b0000, 16'h4321});
        check_frames("ovr");

        // asynchronous reset mid-frame
        for (int c = 0; c < 8; c++) cyc(4'b0001, SEG_TAB[2]);
        for (int c = 0; c < 2; c++) cyc(4'b0010, SEG_TAB[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bcd", bcd_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_overrun", overrun, 0);
        check("arst_err", digit_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b0010, SEG_TAB[2]);
        cyc('0, 7'h00);
        scan_frame(pats_of(0, 0, 7, 1), 5, 1, 1'b1);
        check_frames("arst_recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_to_bcd.md
Name: seg7_scan_to_bcd

Overview:
- Receiver for a multiplexed, scanned 7-segment display bus: the other end of the team's BCD-to-7-segment drive path.
- Watches the one-hot digit strobe and the shared segment lines, waits for each digit's pattern to be stable, and decodes it back to BCD.
- Presents each complete scan frame as one packed BCD word on a valid/ready interface.
- Used for display loopback checking and for reading external 7-segment drivers.

Parameters:
- NUM_DIGITS, 4: digits per scan frame (>=1).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, active high; [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
- digit_sel  input  NUM_DIGITS  digit strobe, active high, one-hot; all-zero means blanking gap.
- bcd_out  output  4*NUM_DIGITS  digit i at [4i+3:4i].
- digit_err  output  NUM_DIGITS  bit i set means digit i held an invalid pattern.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- overrun  output  1  sticky: a completed frame was dropped.
- sync_err  output  1  one-cycle pulse: the scan sequence was broken.

Behaviour:
- Reset (async assert, sync-free deassert): bcd_out=0, digit_err=0, out_valid=0, overrun=0, sync_err=0, state IDLE, idx=0, cnt=0. Reset mid-frame discards the partial frame.
- Inputs are used directly; they are synchronous to clk, with no synchronizer.
- Decode, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern gives nibble 4'hF and sets that digit's error bit.
- FSM states: IDLE, SETTLE, HOLD. Working registers: idx, cnt, last_seg, work_bcd, work_err.
- IDLE:
  - digit_sel==onehot(0) -> SETTLE, idx=0, cnt=1, last_seg=seg_in.
  - All other values -> stay, no sync_err.
- SETTLE, digit_sel==onehot(idx):
  - seg_in==last_seg -> cnt++.
  - seg_in!=last_seg -> cnt=1, last_seg=seg_in.
  - When the incremented cnt equals STABLE_CYCLES, the digit is captured on that edge into work_bcd/work_err, and the FSM goes to HOLD.
  - Captured pattern is seg_in of that cycle.
- SETTLE, digit_sel!=onehot(idx) (zero, multi-hot, or another digit): sync_err=1 for one cycle, -> IDLE, partial frame discarded.
- HOLD:
  - digit_sel==onehot(idx) or all-zero -> stay; seg_in is ignored.
  - idx<NUM_DIGITS-1 and digit_sel==onehot(idx+1) -> SETTLE, idx++, cnt=1.
  - idx==NUM_DIGITS-1 and digit_sel==onehot(0) -> SETTLE, idx=0, cnt=1 (next frame).
  - Any other value (multi-hot, skipped digit, wrong order) -> sync_err pulse, -> IDLE.
- Frame completion happens on the capture edge of digit NUM_DIGITS-1:
  - out_valid==0, or out_valid&&out_ready that cycle: bcd_out/digit_err load the full frame (including the digit being captured), and out_valid=1 on that edge.
  - out_valid&&!out_ready: frame dropped, overrun=1 (sticky until reset), outputs unchanged.
- Handshake:
  - out_valid&&out_ready with no completion that cycle -> out_valid=0 next edge; bcd_out holds its last value.
  - bcd_out and digit_err are stable while out_valid=1.
- NUM_DIGITS=1: after a capture, digit_sel must go to zero before the next frame starts.
- Latency: a digit whose strobe and pattern are stable from cycle t is captured at the end of cycle t+STABLE_CYCLES-1. out_valid is visible the cycle after the last digit's capture edge.

Test Plan:
- N=4, S=4; scan 1,2,3,4 on digits 0..3, 8 cycles each, out_ready=1 -> out_valid pulses with bcd_out=16'h4321, digit_err=0, sync_err never set.
- Digit 2 driven 7'b0000001, others 5 -> bcd_out=16'h5F55, digit_err=4'b0100.
- seg_in on digit 1 toggles every 2 cycles for 6 cycles, then is stable at "7" -> captured 3 cycles after it settles (S-1 after the first stable cycle). Digit 1 nibble=7; no sync_err.
- Digit 1 strobed only 3 cycles (S=4), then digit 2 -> sync_err one cycle, no out_valid for that frame; the next clean frame decodes correctly.
- out_ready=0 across two clean frames ("1234", then "5678") -> first frame held (16'h4321), overrun=1. Raising out_ready -> out_valid=0 next cycle, overrun stays 1.
- digit_sel=4'b0011 during HOLD -> sync_err pulse, FSM returns to IDLE. rst_n asserted mid-frame -> all outputs 0 immediately, without waiting for a clock edge.
